// File: rtl/counter_cascade_n.sv
// Cascaded up/down digit counter, binary or decade per digit.
// Single-cycle carry chain, combinational rco, registered wrap pulse.
module counter_cascade_n #(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 2,
  parameter int MODULUS = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       sclr_n,
  input  logic                       load_n,
  input  logic [DIGIT_W*DIGITS-1:0]  P,
  input  logic                       enp,
  input  logic                       ent,
  input  logic                       up,
  output logic [DIGIT_W*DIGITS-1:0]  Q,
  output logic                       rco,
  output logic                       wrap
);

  localparam int N = DIGIT_W * DIGITS;
  localparam logic [DIGIT_W-1:0] DMAX =
    DIGIT_W'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (1 << DIGIT_W)) begin : g_bad_mod
    $error("counter_cascade_n: MODULUS out of range");
  end

  logic [N-1:0]       q_q;
  logic [N-1:0]       q_d;
  logic [N-1:0]       step;
  logic               wrap_q;
  logic               wrap_d;
  logic               cnt;
  logic               all_t;
  logic [DIGIT_W-1:0] tval;

  assign tval = up ? DMAX : '0;
  assign cnt  = enp & ent;

  // Out-of-range digits never match tval, so they stop the carry.
  always_comb begin
    logic               carry;
    logic [DIGIT_W-1:0] dig;
    logic [DIGIT_W-1:0] nxt;
    carry = cnt;
    all_t = 1'b1;
    step  = q_q;
    dig   = '0;
    nxt   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[i*DIGIT_W +: DIGIT_W];
      nxt = dig;
      if (carry) begin
        if (up) begin
          nxt = (dig >= DMAX) ? '0 : dig + 1'b1;
        end else begin
          nxt = (dig == '0 || dig > DMAX) ? DMAX
                                          : dig - 1'b1;
        end
      end
      step[i*DIGIT_W +: DIGIT_W] = nxt;
      all_t = all_t & (dig == tval);
      carry = carry & (dig == tval);
    end
  end

  assign rco = ent & all_t;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!sclr_n) begin
      q_d = '0;
    end else if (!load_n) begin
      q_d = P;
    end else if (cnt) begin
      q_d    = step;
      wrap_d = rco;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_cascade_n.sv
// Bench for counter_cascade_n: BCD, binary and chained instances.
// Directed scenarios plus a randomized run against a digit model.
module tb_counter_cascade_n;

  logic clk;
  int   checks;
  int   failures;

  // BCD instance, 2 digits
  logic       clr, sclr_n, load_n, enp, ent, up;
  logic [7:0] P, Q;
  logic       rco, wrap;

  // binary instance, 3 digits
  logic        b_clr, b_sclr_n, b_load_n, b_enp, b_ent, b_up;
  logic [11:0] b_P, b_Q;
  logic        b_rco, b_wrap;

  // two binary instances chained rco -> ent
  logic        c_clr, c_sclr_n, c_load_n, c_enp, c_ent, c_up;
  logic [23:0] c_P;
  logic [11:0] l_Q, h_Q;
  logic        l_rco, h_rco, l_wrap, h_wrap;

  counter_cascade_n #(
    .DIGIT_W(4), .DIGITS(2), .MODULUS(10)
  ) dut (
    .clk(clk), .clr(clr), .sclr_n(sclr_n),
    .load_n(load_n), .P(P), .enp(enp), .ent(ent),
    .up(up), .Q(Q), .rco(rco), .wrap(wrap)
  );

  counter_cascade_n #(
    .DIGIT_W(4), .DIGITS(3), .MODULUS(16)
  ) dut_b (
    .clk(clk), .clr(b_clr), .sclr_n(b_sclr_n),
    .load_n(b_load_n), .P(b_P), .enp(b_enp),
    .ent(b_ent), .up(b_up), .Q(b_Q), .rco(b_rco),
    .wrap(b_wrap)
  );

  counter_cascade_n #(
    .DIGIT_W(4), .DIGITS(3), .MODULUS(16)
  ) dut_lo (
    .clk(clk), .clr(c_clr), .sclr_n(c_sclr_n),
    .load_n(c_load_n), .P(c_P[11:0]), .enp(c_enp),
    .ent(c_ent), .up(c_up), .Q(l_Q), .rco(l_rco),
    .wrap(l_wrap)
  );

  counter_cascade_n #(
    .DIGIT_W(4), .DIGITS(3), .MODULUS(16)
  ) dut_hi (
    .clk(clk), .clr(c_clr), .sclr_n(c_sclr_n),
    .load_n(c_load_n), .P(c_P[23:12]), .enp(c_enp),
    .ent(l_rco), .up(c_up), .Q(h_Q), .rco(h_rco),
    .wrap(h_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a number held as base-MOD digits in 4-bit slots.
  function automatic bit m_rco(input int q, input bit u,
                               input bit et, input int md,
                               input int nd);
    bit all;
    all = 1'b1;
    for (int i = 0; i < nd; i++) begin
      if (((q >> (4*i)) & 15) != (u ? md-1 : 0)) all = 1'b0;
    end
    return et & all;
  endfunction

  function automatic void m_next(
    input int q, input bit sc_n, input bit ld_n, input int p,
    input bit ep, input bit et, input bit u, input int md,
    input int nd, output int nq, output bit nw);
    int d, n;
    bit carry;
    nq = q;
    nw = 1'b0;
    if (!sc_n) begin
      nq = 0;
    end else if (!ld_n) begin
      nq = p;
    end else if (ep && et) begin
      nw = m_rco(q, u, 1'b1, md, nd);
      carry = 1'b1;
      nq = 0;
      for (int i = 0; i < nd; i++) begin
        d = (q >> (4*i)) & 15;
        n = d;
        if (carry) begin
          if (u) n = (d >= md-1) ? 0 : d + 1;
          else   n = (d == 0 || d > md-1) ? md-1 : d - 1;
        end
        carry = carry && (d == (u ? md-1 : 0));
        nq = nq | (n << (4*i));
      end
    end
  endfunction

  task automatic test_reset();
    clr = 1'b1; sclr_n = 1'b1; load_n = 1'b1;
    enp = 1'b0; ent = 1'b0; up = 1'b1; P = 8'h00;
    #2;
    checks++;
    if (Q !== 8'h00 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_init Q=%h wrap=%b exp 00/0", Q, wrap);
    end
    tick();
    clr = 1'b0; load_n = 1'b0; P = 8'h37;
    tick();
    checks++;
    if (Q !== 8'h37) begin
      failures++;
      $display("FAIL reset_load Q=%h exp 37", Q);
    end
    load_n = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (Q !== 8'h00 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_async Q=%h wrap=%b exp 00/0",
               Q, wrap);
    end
    tick();
    clr = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (Q !== 8'(k)) begin
        failures++;
        $display("FAIL reset_resume Q=%h exp %h", Q, 8'(k));
      end
    end
  endtask

  task automatic test_bcd_wrap();
    load_n = 1'b0; P = 8'h98; up = 1'b1;
    tick();
    load_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h99 || rco !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL bcd_99 Q=%h rco=%b wrap=%b exp 99/1/0",
               Q, rco, wrap);
    end
    tick();
    checks++;
    if (Q !== 8'h00 || rco !== 1'b0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL bcd_wrap Q=%h rco=%b wrap=%b exp 00/0/1",
               Q, rco, wrap);
    end
    tick();
    checks++;
    if (Q !== 8'h01 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL bcd_after Q=%h wrap=%b exp 01/0", Q, wrap);
    end
    load_n = 1'b0; P = 8'h09;
    tick();
    load_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h10) begin
      failures++;
      $display("FAIL bcd_carry Q=%h exp 10", Q);
    end
  endtask

  task automatic test_down();
    load_n = 1'b0; P = 8'h10; up = 1'b0;
    tick();
    load_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h09) begin
      failures++;
      $display("FAIL down_borrow Q=%h exp 09", Q);
    end
    tick();
    checks++;
    if (Q !== 8'h08) begin
      failures++;
      $display("FAIL down_step Q=%h exp 08", Q);
    end
    load_n = 1'b0; P = 8'h00; enp = 1'b0;
    tick();
    load_n = 1'b1;
    #1;
    checks++;
    if (rco !== 1'b1) begin
      failures++;
      $display("FAIL down_rco rco=%b exp 1", rco);
    end
    ent = 1'b0;
    #1;
    checks++;
    if (rco !== 1'b0) begin
      failures++;
      $display("FAIL down_rco_ent rco=%b exp 0", rco);
    end
    ent = 1'b1; enp = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h99 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap Q=%h wrap=%b exp 99/1", Q, wrap);
    end
  endtask

  task automatic test_priority();
    up = 1'b1; enp = 1'b0; ent = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h99 || rco !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL hold Q=%h rco=%b wrap=%b exp 99/1/0",
               Q, rco, wrap);
    end
    ent = 1'b0;
    #1;
    checks++;
    if (rco !== 1'b0) begin
      failures++;
      $display("FAIL hold_ent rco=%b exp 0", rco);
    end
    enp = 1'b1; ent = 1'b1;
    load_n = 1'b0; sclr_n = 1'b0; P = 8'h55;
    tick();
    checks++;
    if (Q !== 8'h00 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL sclr_wins Q=%h wrap=%b exp 00/0", Q, wrap);
    end
    sclr_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h55) begin
      failures++;
      $display("FAIL load_wins Q=%h exp 55", Q);
    end
    load_n = 1'b1;
  endtask

  task automatic test_out_of_range();
    up = 1'b1; enp = 1'b1; ent = 1'b1;
    load_n = 1'b0; P = 8'hFC;
    tick();
    checks++;
    if (Q !== 8'hFC || rco !== 1'b0) begin
      failures++;
      $display("FAIL oor_load Q=%h rco=%b exp FC/0", Q, rco);
    end
    load_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'hF0) begin
      failures++;
      $display("FAIL oor_step Q=%h exp F0", Q);
    end
    tick();
    checks++;
    if (Q !== 8'hF1) begin
      failures++;
      $display("FAIL oor_step2 Q=%h exp F1", Q);
    end
    load_n = 1'b0; P = 8'hF9;
    tick();
    load_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h00 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL oor_carry Q=%h wrap=%b exp 00/0", Q, wrap);
    end
    up = 1'b0; load_n = 1'b0; P = 8'h0C;
    tick();
    load_n = 1'b1;
    tick();
    checks++;
    if (Q !== 8'h09) begin
      failures++;
      $display("FAIL oor_down Q=%h exp 09", Q);
    end
  endtask

  task automatic test_clr_rco();
    up = 1'b0; ent = 1'b1; enp = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (Q !== 8'h00 || rco !== 1'b1) begin
      failures++;
      $display("FAIL clr_rco_dn Q=%h rco=%b exp 00/1", Q, rco);
    end
    up = 1'b1;
    #1;
    checks++;
    if (rco !== 1'b0) begin
      failures++;
      $display("FAIL clr_rco_up rco=%b exp 0", rco);
    end
    tick();
    clr = 1'b0;
  endtask

  task automatic test_binary();
    b_clr = 1'b0; b_sclr_n = 1'b1; b_up = 1'b1;
    b_enp = 1'b1; b_ent = 1'b1;
    b_load_n = 1'b0; b_P = 12'hFFE;
    tick();
    b_load_n = 1'b1;
    tick();
    checks++;
    if (b_Q !== 12'hFFF || b_rco !== 1'b1) begin
      failures++;
      $display("FAIL bin_fff Q=%h rco=%b exp FFF/1", b_Q, b_rco);
    end
    tick();
    checks++;
    if (b_Q !== 12'h000 || b_wrap !== 1'b1) begin
      failures++;
      $display("FAIL bin_wrap Q=%h wrap=%b exp 000/1",
               b_Q, b_wrap);
    end
    tick();
    checks++;
    if (b_Q !== 12'h001 || b_wrap !== 1'b0) begin
      failures++;
      $display("FAIL bin_after Q=%h wrap=%b exp 001/0",
               b_Q, b_wrap);
    end
  endtask

  task automatic test_chain();
    int v;
    c_clr = 1'b0; c_sclr_n = 1'b1; c_up = 1'b1;
    c_enp = 1'b1; c_ent = 1'b1;
    for (int s = 0; s < 2; s++) begin
      v = (s == 0) ? 24'h000FFC : 24'hFFFFFD;
      c_load_n = 1'b0; c_P = 24'(v);
      tick();
      c_load_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
        tick();
        v = (v + 1) & 24'hFFFFFF;
        checks++;
        if ({h_Q, l_Q} !== 24'(v)) begin
          failures++;
          $display("FAIL chain Q=%h exp %h", {h_Q, l_Q}, 24'(v));
        end
        checks++;
        if (h_wrap !== (v == 0)) begin
          failures++;
          $display("FAIL chain_wrap wrap=%b exp %b",
                   h_wrap, (v == 0));
        end
      end
    end
  endtask

  task automatic test_random();
    int mq, nq;
    bit mw, nw;
    sclr_n = 1'b0; load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    up = 1'b1;
    tick();
    mq = 0;
    mw = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      sclr_n = ($urandom_range(0, 40) != 0);
      load_n = ($urandom_range(0, 12) != 0);
      if ($urandom_range(0, 1) == 0)
        P = 8'($urandom_range(0, 255));
      else
        P = 8'(($urandom_range(0, 9) << 4)
               | $urandom_range(0, 9));
      enp = ($urandom_range(0, 3) != 0);
      ent = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 20) == 0) up = ~up;
      #1;
      checks++;
      if (rco !== m_rco(mq, up, ent, 10, 2)) begin
        failures++;
        $display("FAIL rand_rco Q=%h up=%b rco=%b exp %b",
                 Q, up, rco, m_rco(mq, up, ent, 10, 2));
      end
      m_next(mq, sclr_n, load_n, int'(P), enp, ent, up,
             10, 2, nq, nw);
      tick();
      mq = nq;
      mw = nw;
      checks++;
      if (Q !== 8'(mq) || wrap !== mw) begin
        failures++;
        $display("FAIL rand_q Q=%h wrap=%b exp %h/%b",
                 Q, wrap, 8'(mq), mw);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    b_clr = 1'b1; b_sclr_n = 1'b1; b_load_n = 1'b1;
    b_enp = 1'b0; b_ent = 1'b0; b_up = 1'b1; b_P = '0;
    c_clr = 1'b1; c_sclr_n = 1'b1; c_load_n = 1'b1;
    c_enp = 1'b0; c_ent = 1'b0; c_up = 1'b1; c_P = '0;
    test_reset();
    test_bcd_wrap();
    test_down();
    test_priority();
    test_out_of_range();
    test_clr_rco();
    test_binary();
    test_chain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
